// File: rtl/ex_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ex_pkg
// Description : Shared ALU selector / opcode encodings and the divider FSM
//               state type for the MIPS execute stage.
// Revision    : 1.0 - initial release
// ============================================================================
package ex_pkg;

  // Operation classes
  localparam logic [2:0] ALUSEL_NOP   = 3'b000;
  localparam logic [2:0] ALUSEL_LOGIC = 3'b001;
  localparam logic [2:0] ALUSEL_SHIFT = 3'b010;
  localparam logic [2:0] ALUSEL_MOVE  = 3'b011;
  localparam logic [2:0] ALUSEL_ARITH = 3'b100;

  // Operation codes
  localparam logic [7:0] ALUOP_OR   = 8'b0010_0101;
  localparam logic [7:0] ALUOP_AND  = 8'b0010_0100;
  localparam logic [7:0] ALUOP_XOR  = 8'b0010_0110;
  localparam logic [7:0] ALUOP_NOR  = 8'b0010_0111;
  localparam logic [7:0] ALUOP_SLL  = 8'b0111_1100;
  localparam logic [7:0] ALUOP_SRL  = 8'b0000_0010;
  localparam logic [7:0] ALUOP_SRA  = 8'b0000_0011;
  localparam logic [7:0] ALUOP_ADDU = 8'b0010_0001;
  localparam logic [7:0] ALUOP_SUBU = 8'b0010_0011;
  localparam logic [7:0] ALUOP_SLT  = 8'b0010_1010;
  localparam logic [7:0] ALUOP_SLTU = 8'b0010_1011;
  localparam logic [7:0] ALUOP_MFHI = 8'b0001_0000;
  localparam logic [7:0] ALUOP_MFLO = 8'b0001_0010;
  localparam logic [7:0] ALUOP_DIV  = 8'b0001_1010;
  localparam logic [7:0] ALUOP_DIVU = 8'b0001_1011;

  // Divider sequencing states
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } div_state_e;

endpackage : ex_pkg
`default_nettype wire

// File: rtl/ex_div_unit.sv
`default_nettype none
// ============================================================================
// Module      : ex_div_unit
// Description : Iterative radix-2 restoring divider, one quotient bit per
//               cycle, with signed fix-up and divide-by-zero shortcut.
// Revision    : 1.0 - initial release
// ============================================================================
module ex_div_unit
  import ex_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int DIV_CYCLES = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic              signed_flag_i,
  input  logic [DATA_W-1:0] opa_i,
  input  logic [DATA_W-1:0] opb_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [DATA_W-1:0] quotient_o,
  output logic [DATA_W-1:0] remainder_o
);

  localparam int CNT_W = $clog2(DIV_CYCLES);

  div_state_e              state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [2*DATA_W-1:0]     pr_q, pr_d;     // {remainder, dividend/quotient}
  logic [DATA_W-1:0]       dvs_q, dvs_d;
  logic                    qneg_q, qneg_d;
  logic                    rneg_q, rneg_d;
  logic [DATA_W-1:0]       qhold_q, qhold_d;
  logic [DATA_W-1:0]       rhold_q, rhold_d;

  logic [DATA_W-1:0]       opa_abs, opb_abs;
  logic [DATA_W:0]         trial;          // shifted upper half minus divisor
  logic [DATA_W-1:0]       q_fix, r_fix;

  // Divider state registers with asynchronous clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      pr_q    <= '0;
      dvs_q   <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      qhold_q <= '0;
      rhold_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pr_q    <= pr_d;
      dvs_q   <= dvs_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      qhold_q <= qhold_d;
      rhold_q <= rhold_d;
    end
  end

  // Next-state, operand capture and one restoring step per BUSY cycle
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pr_d    = pr_q;
    dvs_d   = dvs_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    qhold_d = qhold_q;
    rhold_d = rhold_q;

    opa_abs = (signed_flag_i && opa_i[DATA_W-1]) ? -opa_i : opa_i;
    opb_abs = (signed_flag_i && opb_i[DATA_W-1]) ? -opb_i : opb_i;
    // The upper half is taken one bit wider so a remainder >= 2^(W-1)
    // does not lose its MSB when shifted.
    trial   = pr_q[2*DATA_W-1:DATA_W-1] - {1'b0, dvs_q};

    q_fix = qneg_q ? -pr_q[DATA_W-1:0] : pr_q[DATA_W-1:0];
    r_fix = rneg_q ? -pr_q[2*DATA_W-1:DATA_W] : pr_q[2*DATA_W-1:DATA_W];

    case (state_q)
      IDLE: begin
        if (start_i) begin
          if (opb_i == '0) begin
            // Divide by zero: all-ones quotient, raw dividend as remainder
            pr_d    = {opa_i, {DATA_W{1'b1}}};
            qneg_d  = 1'b0;
            rneg_d  = 1'b0;
            state_d = DONE;
          end else begin
            pr_d    = {{DATA_W{1'b0}}, opa_abs};
            dvs_d   = opb_abs;
            qneg_d  = signed_flag_i & (opa_i[DATA_W-1] ^ opb_i[DATA_W-1]);
            rneg_d  = signed_flag_i & opa_i[DATA_W-1];
            cnt_d   = '0;
            state_d = BUSY;
          end
        end
      end
      BUSY: begin
        if (!trial[DATA_W]) begin
          pr_d = {trial[DATA_W-1:0], pr_q[DATA_W-2:0], 1'b1};
        end else begin
          pr_d = {pr_q[2*DATA_W-2:0], 1'b0};
        end
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(DIV_CYCLES - 1)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        qhold_d = q_fix;
        rhold_d = r_fix;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Stall is asserted on the issue cycle and throughout iteration
  assign busy_o      = ~rst & (((state_q == IDLE) & start_i) | (state_q == BUSY));
  assign done_o      = (state_q == DONE);
  assign quotient_o  = done_o ? q_fix : qhold_q;
  assign remainder_o = done_o ? r_fix : rhold_q;

endmodule : ex_div_unit
`default_nettype wire

// File: rtl/ex.sv
`default_nettype none
// ============================================================================
// Module      : ex
// Description : MIPS execute stage - combinational ALU result mux plus the
//               HI/LO write path from the iterative divider.
// Revision    : 1.0 - initial release
// ============================================================================
module ex
  import ex_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int DIV_CYCLES = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [2:0]        alusel_i,
  input  logic [7:0]        aluop_i,
  input  logic [DATA_W-1:0] reg1_i,
  input  logic [DATA_W-1:0] reg2_i,
  input  logic [4:0]        wd_i,
  input  logic              wreg_i,
  input  logic [DATA_W-1:0] hi_i,
  input  logic [DATA_W-1:0] lo_i,
  output logic [4:0]        wd_o,
  output logic              wreg_o,
  output logic [DATA_W-1:0] wdata_o,
  output logic              whilo_o,
  output logic [DATA_W-1:0] hi_o,
  output logic [DATA_W-1:0] lo_o,
  output logic              stallreq_o
);

  logic div_start;
  logic div_signed;

  assign wd_o   = wd_i;
  assign wreg_o = wreg_i;

  assign div_start  = (aluop_i == ALUOP_DIV) || (aluop_i == ALUOP_DIVU);
  assign div_signed = (aluop_i == ALUOP_DIV);

  // Result select by operation class; anything unrecognised yields zero
  always_comb begin
    wdata_o = '0;
    case (alusel_i)
      ALUSEL_LOGIC: begin
        case (aluop_i)
          ALUOP_OR:  wdata_o = reg1_i | reg2_i;
          ALUOP_AND: wdata_o = reg1_i & reg2_i;
          ALUOP_XOR: wdata_o = reg1_i ^ reg2_i;
          ALUOP_NOR: wdata_o = ~(reg1_i | reg2_i);
          default:   wdata_o = '0;
        endcase
      end
      ALUSEL_SHIFT: begin
        case (aluop_i)
          ALUOP_SLL: wdata_o = reg2_i << reg1_i[4:0];
          ALUOP_SRL: wdata_o = reg2_i >> reg1_i[4:0];
          ALUOP_SRA: wdata_o = $unsigned($signed(reg2_i) >>> reg1_i[4:0]);
          default:   wdata_o = '0;
        endcase
      end
      ALUSEL_ARITH: begin
        case (aluop_i)
          ALUOP_ADDU: wdata_o = reg1_i + reg2_i;
          ALUOP_SUBU: wdata_o = reg1_i - reg2_i;
          ALUOP_SLT:  wdata_o = {{(DATA_W-1){1'b0}}, ($signed(reg1_i) < $signed(reg2_i))};
          ALUOP_SLTU: wdata_o = {{(DATA_W-1){1'b0}}, (reg1_i < reg2_i)};
          default:    wdata_o = '0;
        endcase
      end
      ALUSEL_MOVE: begin
        case (aluop_i)
          ALUOP_MFHI: wdata_o = hi_i;
          ALUOP_MFLO: wdata_o = lo_i;
          default:    wdata_o = '0;
        endcase
      end
      default: wdata_o = '0;
    endcase
  end

  ex_div_unit #(
    .DATA_W     (DATA_W),
    .DIV_CYCLES (DIV_CYCLES)
  ) u_div (
    .clk           (clk),
    .rst           (rst),
    .start_i       (div_start),
    .signed_flag_i (div_signed),
    .opa_i         (reg1_i),
    .opb_i         (reg2_i),
    .busy_o        (stallreq_o),
    .done_o        (whilo_o),
    .quotient_o    (lo_o),
    .remainder_o   (hi_o)
  );

endmodule : ex
`default_nettype wire
